// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIV_WIDTH_DEFAULT = 4;

  // Iteration counter width; sized to hold WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_o
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] dvs;

  // r_i stays below the divisor between iterations, so its top bit is normally 0;
  // if it were set, the shifted value would exceed any divisor and must subtract.
  always_comb begin
    r_sh = {r_i[WIDTH-1:0], msb_i};
    dvs  = {1'b0, divisor_i};
    q_o  = r_i[WIDTH] | (r_sh >= dvs);
    r_o  = q_o ? (r_sh - dvs) : r_sh;
  end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results held until next start.
// DIVIDER_ZERO_CHECK_EN: zero divisor skips RUN and flags div_by_zero with a 1-edge latency.
module divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   step_r;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .msb_i     (dividend_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

`ifdef DIVIDER_ZERO_CHECK_EN
  logic dbz_q, dbz_d;
`endif

  // Quotient bits shift into the dividend register as its bits are consumed.
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    dbz_d      = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          dividend_d = A;
          divisor_d  = B;
          r_d        = '0;
          cnt_d      = '0;
          state_d    = RUN;
`ifdef DIVIDER_ZERO_CHECK_EN
          dbz_d      = 1'b0;
          if (B == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = A;
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        r_d        = step_r;
        dividend_d = {dividend_q[WIDTH-2:0], step_q};
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = {dividend_q[WIDTH-2:0], step_q};
          rem_d   = step_r[WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

`ifdef DIVIDER_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: a 4-bit instance checked by a decoupled monitor, plus an 8-bit instance.
module tb_divider_seq;

`ifdef DIVIDER_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] A, B;
  logic       busy, done, dbz;
  logic [3:0] quotient, remainder;

  logic       start8;
  logic [7:0] A8, B8;
  logic       busy8, done8, dbz8;
  logic [7:0] quot8, rem8;

  always #5 clk = ~clk;

  divider_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(dbz)
  );

  divider_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .quotient(quot8), .remainder(rem8),
    .div_by_zero(dbz8)
  );

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   phase_dones[$];
  bit   record_dones = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [3:0] hold_q = '0;
  logic [3:0] hold_r = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: plain integer division, with the architected zero-divisor result.
  task automatic model(input int w, input int a, input int b,
                       output int q, output int r, output bit z);
    if (b == 0) begin
      q = (1 << w) - 1;
      r = a;
      z = ZCHK;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        chk("busy_with_done", {31'd0, busy}, 32'd0);
        if (record_dones) phase_dones.push_back(cyc);
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("quotient", {28'd0, quotient}, {28'd0, e.q});
          chk("remainder", {28'd0, remainder}, {28'd0, e.r});
          chk("div_by_zero", {31'd0, dbz}, {31'd0, e.dbz});
          chk("latency_cycle", cyc, e.cyc);
          hold_q = e.q;
          hold_r = e.r;
        end
      end else begin
        chk("held_result", {24'd0, quotient, remainder}, {24'd0, hold_q, hold_r});
      end
    end
  end

  // Waits for IDLE, presents operands for one accepting edge, then scrambles A/B.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input bit push, input bit hold);
    int n;
    int q, r;
    bit z;
    exp_t e;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
    A = a;
    B = b;
    start = 1'b1;
    if (push) begin
      model(4, int'(a), int'(b), q, r, z);
      e.q = 4'(q);
      e.r = 4'(r);
      e.dbz = z;
      e.cyc = cyc + 1 + ((b == 4'd0 && ZCHK) ? 0 : 4);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    A = 4'($urandom);
    B = 4'($urandom);
    if (!hold) start = 1'b0;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int n, q, r, lat;
    bit z;
    model(8, int'(a), int'(b), q, r, z);
    lat = (b == 8'd0 && ZCHK) ? 1 : 9;
    @(negedge clk);
    A8 = a;
    B8 = b;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    A8 = 8'($urandom);
    B8 = 8'($urandom);
    n = 1;
    while (!done8 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w8_latency", n, lat);
    chk("w8_quotient", {24'd0, quot8}, q);
    chk("w8_remainder", {24'd0, rem8}, r);
    chk("w8_div_by_zero", {31'd0, dbz8}, {31'd0, z});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    start8 = 1'b0;
    A8 = '0;
    B8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {28'd0, quotient}, 32'd0);
    chk("rst_remainder", {28'd0, remainder}, 32'd0);
    chk("rst_div_by_zero", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'b0111, 4'b0010, 1'b1, 1'b0);
    issue(4'b1001, 4'b0100, 1'b1, 1'b0);
    issue(4'b1111, 4'b1111, 1'b1, 1'b0);
    issue(4'b0011, 4'b0101, 1'b1, 1'b0);
    issue(4'b1111, 4'b0000, 1'b1, 1'b0);

    // start held high: accepts must land every WIDTH+2 cycles
    issue(4'b1100, 4'b0011, 1'b1, 1'b0);
    record_dones = 1'b1;
    for (int i = 0; i < 5; i++)
      issue(4'($urandom), 4'($urandom_range(1, 15)), 1'b1, 1'b1);
    start = 1'b0;
    n = 0;
    while (phase_dones.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    record_dones = 1'b0;
    chk("held_done_count", phase_dones.size(), 32'd5);
    for (int i = 1; i < phase_dones.size(); i++)
      chk("held_accept_gap", phase_dones[i] - phase_dones[i-1], 32'd6);

    // abort after two iterations; no done may follow
    issue(4'b1110, 4'b0011, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", {28'd0, quotient}, 32'd0);
    chk("abort_remainder", {28'd0, remainder}, 32'd0);
    chk("abort_div_by_zero", {31'd0, dbz}, 32'd0);
    hold_q = '0;
    hold_r = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(4'b1110, 4'b0011, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++)
      issue(4'($urandom), 4'($urandom_range(0, 15)), 1'b1, 1'b0);

    n = 0;
    while ((sbq.size() != 0 || busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 32'd0);

    run8(8'd200, 8'd7);
    run8(8'd255, 8'd0);
    for (int i = 0; i < 6; i++)
      run8(8'($urandom), 8'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
